// File: rtl/mem_pkg.sv
// Shared encodings for the byte-addressed data memory: access sizes, byte-enable width, FSM states.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned BE_WIDTH = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Size/lane decode: store byte enables and data replication, load lane extraction and extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]          size,
  input  logic [1:0]          lane,
  input  logic                is_unsigned,
  input  logic [31:0]         wr_data,
  input  logic [31:0]         rd_word,
  output logic [BE_WIDTH-1:0] be,
  output logic [31:0]         wr_word,
  output logic [31:0]         ld_data
);

  logic [31:0] shifted;

  always_comb begin
    be      = '0;
    wr_word = wr_data;
    unique case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << lane;
        wr_word = {4{wr_data[7:0]}};
      end
      SZ_HALF: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wr_data[15:0]}};
      end
      SZ_WORD: begin
        be      = 4'b1111;
        wr_word = wr_data;
      end
      default: begin
        be      = '0;
        wr_word = wr_data;
      end
    endcase
  end

  // Addressed lane(s) are brought down to bit 0 before extension.
  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    ld_data = '0;
    unique case (size)
      SZ_BYTE: ld_data = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
      SZ_HALF: ld_data = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
      SZ_WORD: ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressed little-endian data memory with post-reset zero sweep and registered response.
module byte_data_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4000,
  parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  output logic                  resp_valid,
  output logic [31:0]           rd_data,
  output logic                  fault,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(DEPTH - 1);

  mem_state_t           state;
  logic [IDX_WIDTH-1:0] clr_idx;
  logic [31:0]          mem [DEPTH];

  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IDX_WIDTH-1:0]  mem_idx;
  logic [1:0]            lane;
  logic                  req_fault;
  logic                  accept;
  logic [BE_WIDTH-1:0]   be;
  logic [31:0]           wr_word;
  logic [31:0]           rd_word;
  logic [31:0]           ld_data;

  assign word_idx  = addr[ADDR_WIDTH-1:2];
  assign mem_idx   = word_idx[IDX_WIDTH-1:0];
  assign lane      = addr[1:0];
  assign req_ready = (state == RUN);
  assign init_done = (state == RUN);
  assign accept    = req_valid && req_ready && !reset;

  always_comb begin
    req_fault = 1'b0;
    if (req_size == 2'd3)                           req_fault = 1'b1;
    else if (req_size == SZ_HALF && addr[0])        req_fault = 1'b1;
    else if (req_size == SZ_WORD && addr[1:0] != 0) req_fault = 1'b1;
    else if (word_idx >= DEPTH_W)                   req_fault = 1'b1;
  end

  // Out-of-range indices alias into the array; they are always faulted, so the read is discarded.
  assign rd_word = mem[mem_idx];

  mem_lane_align u_align (
    .size        (req_size),
    .lane        (lane),
    .is_unsigned (req_unsigned),
    .wr_data     (wr_data),
    .rd_word     (rd_word),
    .be          (be),
    .wr_word     (wr_word),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST_IDX) state <= RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_we && !req_fault) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (be[i]) mem[mem_idx][i*8 +: 8] <= wr_word[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      fault      <= 1'b0;
      rd_data    <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      fault      <= req_fault;
      rd_data    <= (!req_fault && !req_we) ? ld_data : '0;
    end else begin
      resp_valid <= 1'b0;
      fault      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_data_memory.sv
// Directed bench for byte_data_memory at DEPTH = 16: sweep, lane merge, faults, back-to-back, reset, gating.
module tb_byte_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        resp_valid;
  logic [31:0] rd_data;
  logic        fault;
  logic        init_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  byte_data_memory #(
    .ADDR_WIDTH (32),
    .DEPTH      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .addr         (addr),
    .wr_data      (wr_data),
    .resp_valid   (resp_valid),
    .rd_data      (rd_data),
    .fault        (fault),
    .init_done    (init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request for a single cycle; returns at the following negedge with the response visible.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns; addr = a; wr_data = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic f, input logic [31:0] d);
    check({tag, ".valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, ".fault"}, {31'b0, fault}, {31'b0, f});
    check({tag, ".data"}, rd_data, d);
  endtask

  // Counts posedges after reset release until req_ready rises (bounded).
  task automatic count_sweep(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (req_ready) begin n = i; break; end
    end
  endtask

  int n;
  int first_resp;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; addr = '0; wr_data = '0;

    // Clear sweep
    @(posedge clk); @(posedge clk); #1;
    check("rst.ready", {31'b0, req_ready}, 32'd0);
    check("rst.init_done", {31'b0, init_done}, 32'd0);
    check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst.rd_data", rd_data, 32'd0);
    @(negedge clk); reset = 1'b0;
    count_sweep(n);
    check("clear.ready_edge", n, 32'd16);
    check("clear.init_done", {31'b0, init_done}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h00, 32'h0); expect_resp("clear.ld0", 1'b0, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0); expect_resp("clear.ld20", 1'b0, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0); expect_resp("clear.ld3c", 1'b0, 32'h0);

    // Byte merge
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344); expect_resp("st.w8", 1'b0, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h9, 32'h000000AA); expect_resp("st.b9", 1'b0, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'hA, 32'h0000BEEF); expect_resp("st.hA", 1'b0, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0); expect_resp("ld.w8", 1'b0, 32'hBEEFAA44);
    do_req(1'b0, 2'd0, 1'b0, 32'h9, 32'h0); expect_resp("ld.b9s", 1'b0, 32'hFFFFFFAA);
    do_req(1'b0, 2'd0, 1'b1, 32'h9, 32'h0); expect_resp("ld.b9u", 1'b0, 32'h000000AA);
    do_req(1'b0, 2'd1, 1'b0, 32'hA, 32'h0); expect_resp("ld.hAs", 1'b0, 32'hFFFFBEEF);
    do_req(1'b0, 2'd1, 1'b1, 32'hA, 32'h0); expect_resp("ld.hAu", 1'b0, 32'h0000BEEF);
    do_req(1'b0, 2'd0, 1'b1, 32'h8, 32'h0); expect_resp("ld.b8u", 1'b0, 32'h00000044);

    // Faults
    do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h55667788); expect_resp("st.w4", 1'b0, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h5, 32'h0); expect_resp("flt.half5", 1'b1, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h6, 32'hFFFFFFFF); expect_resp("flt.word6", 1'b1, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF); expect_resp("flt.size3", 1'b1, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hFFFFFFFF); expect_resp("flt.range", 1'b1, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0); expect_resp("flt.ld4", 1'b0, 32'h55667788);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0); expect_resp("flt.ld0", 1'b0, 32'h0);
    @(negedge clk);
    check("idle.valid", {31'b0, resp_valid}, 32'd0);
    check("idle.fault", {31'b0, fault}, 32'd0);

    // Back-to-back store then load
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; addr = 32'h10; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    expect_resp("b2b.st", 1'b0, 32'h0);
    req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    expect_resp("b2b.ld", 1'b0, 32'hDEADBEEF);

    // Reset during an in-flight load
    do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678); expect_resp("rr.st", 1'b0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; addr = 32'h0; reset = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rr.suppressed", {31'b0, resp_valid}, 32'd0);
    check("rr.ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    count_sweep(n);
    check("rr.ready_edge", n, 32'd16);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0); expect_resp("rr.ld0", 1'b0, 32'h0);

    // Gating: request held through the sweep
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; addr = 32'h4; wr_data = 32'h0BADF00D;
    first_resp = 0; n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (req_ready && n == 0) n = i;
      if (resp_valid) begin first_resp = i; req_valid = 1'b0; break; end
    end
    check("gate.ready_edge", n, 32'd16);
    check("gate.first_resp", first_resp, 32'd17);
    check("gate.fault", {31'b0, fault}, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0); expect_resp("gate.ld4", 1'b0, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_data_memory.md
Name: byte_data_memory

Overview:
- Parametrised successor to the single-cycle word data memory used by the CPU datapath.
- Byte-addressed, little-endian, word-organised RAM supporting byte, halfword and word loads and stores, with sign or zero extension on loads.
- After reset, a hardware sweep zero-fills the array, so every location reads 0 until written.
- Request/response handshake: registered (1-cycle) read and fault reporting for misaligned or out-of-range accesses.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 4000, number of 32-bit words; need not be a power of 2.
- IDX_WIDTH, $clog2(DEPTH), word-index width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  block can accept a request (0 during clear sweep).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  ADDR_WIDTH  byte address.
- wr_data  in  32  store data; byte/half stores use the low 8/16 bits.
- resp_valid  out  1  one-cycle pulse, one cycle after each accepted request.
- rd_data  out  32  load result, valid when resp_valid is 1 and the request was a load; 0 otherwise.
- fault  out  1  qualifies resp_valid: the request was rejected.
- init_done  out  1  high once the clear sweep is complete.

Behaviour:
- Reset (any cycle, including mid-sweep or mid-request):
  - state <= CLEAR, clr_idx <= 0.
  - req_ready = 0, resp_valid = 0, fault = 0, rd_data = 0, init_done = 0.
  - Any in-flight response is dropped.
- CLEAR state:
  - Each cycle writes mem[clr_idx] <= 0 and increments clr_idx.
  - When clr_idx == DEPTH-1, that write completes and state goes to RUN.
  - req_ready and init_done rise exactly DEPTH edges after the last edge with reset high.
  - Requests are ignored while req_ready = 0.
- RUN state:
  - req_ready = 1 every cycle. The block never stalls.
  - A request is accepted when req_valid && req_ready.
  - Word index = addr[ADDR_WIDTH-1:2]; lane = addr[1:0].
- Fault conditions, checked in priority order:
  1. req_size == 3.
  2. Half access with addr[0] = 1.
  3. Word access with addr[1:0] != 0.
  4. Word index >= DEPTH.
  - A faulting request has no memory side effect. On the next cycle resp_valid = 1, fault = 1, rd_data = 0.
- Stores:
  - Only the addressed lanes are written on the accepting edge: byte = one lane; half = lanes {addr[1],0} and {addr[1],1}; word = all four.
  - Unaddressed lanes are preserved.
  - Next cycle: resp_valid = 1, fault = 0, rd_data = 0.
- Loads:
  - The array is read at the accepting edge into the response register.
  - Next cycle: resp_valid = 1, rd_data = the extracted lane(s) shifted to bit 0, then extended per req_unsigned. Word loads ignore req_unsigned.
- Read-after-write:
  - A load accepted the cycle after a store to the same word returns the post-store value (the store has already committed).
  - Only one request is accepted per cycle.
- Output registers:
  - resp_valid, fault and rd_data are registered.
  - With no accepted request, resp_valid = 0 and fault = 0 on the next cycle; rd_data holds its last value.

Decomposition:
- Package mem_pkg holds:
  - Size encodings SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2.
  - Byte-enable width 4.
  - The FSM state enum {CLEAR, RUN}.
- One combinational sub-module, mem_lane_align, generates byte enables and the write-data replication from size/lane. It also performs the load lane extraction and extension.
- The FSM, clear counter, array and response registers live in byte_data_memory.

Test Plan:
All scenarios use DEPTH = 16.
- Clear: hold reset 2 cycles, release, pre-load nothing. req_ready rises at edge 16; word loads of 0x0, 0x20 and 0x3C all return 0 with fault = 0.
- Byte merge:
  - Stores: word 0x11223344 @0x8, byte 0xAA @0x9, half 0xBEEF @0xA.
  - Then word load @0x8 -> 0xBEEFAA44.
  - Then load byte signed @0x9 -> 0xFFFFFFAA, unsigned -> 0x000000AA.
  - Then load half signed @0xA -> 0xFFFFBEEF.
- Faults:
  - Half load @0x5, word store @0x6, size = 3 @0x0, and word store @0x40: each gives resp_valid = 1, fault = 1, rd_data = 0.
  - A follow-up load @0x4 shows the prior contents unchanged.
- Back-to-back: store 0xDEADBEEF @0x10 then load @0x10 on the next cycle. resp_valid is high two cycles in a row, and the second response is 0xDEADBEEF.
- Reset mid-operation: write 0x12345678 @0x0, then assert reset while a load is in flight. The pending resp_valid is suppressed, req_ready stays 0 for 16 cycles, and a load @0x0 then returns 0.
- Gating: req_valid held high throughout the clear sweep with a store @0x4. No response appears until RUN; the store is only accepted once req_ready = 1.
